data_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported DataMemory. It lets the CPU load/store stage (port 0) and a secondary master such as a debug/DMA engine (port 1) share the memory. Each request is accepted through a valid/ready handshake and granted round-robin. The block drives exactly one memory access for the request and returns a registered, single-cycle response pulse to the owning port.

---
 rtl/data_memory_arbiter_if.sv | 44 ++++
 rtl/data_memory_arbiter.sv | 66 ++++++
 tb/tb_data_memory_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: request/response handshake for both ports plus the DataMemory side bus
interface data_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  Req_Valid_0;
    logic                  Req_Valid_1;
    logic                  Req_Write_0;
    logic                  Req_Write_1;
    logic [ADDR_WIDTH-1:0] Req_Address_0;
    logic [ADDR_WIDTH-1:0] Req_Address_1;
    logic [DATA_WIDTH-1:0] Req_Write_Data_0;
    logic [DATA_WIDTH-1:0] Req_Write_Data_1;
    logic                  Req_Ready_0;
    logic                  Req_Ready_1;
    logic                  Resp_Valid_0;
    logic                  Resp_Valid_1;
    logic [DATA_WIDTH-1:0] Resp_Read_Data_0;
    logic [DATA_WIDTH-1:0] Resp_Read_Data_1;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Write_Data;
    logic                  Sig_Mem_Write;
    logic                  Sig_Mem_Read;
    logic [DATA_WIDTH-1:0] Read_Data;
    logic                  Busy;

    modport slave (
        input  Req_Valid_0, Req_Valid_1, Req_Write_0, Req_Write_1,
        input  Req_Address_0, Req_Address_1, Req_Write_Data_0, Req_Write_Data_1,
        input  Read_Data,
        output Req_Ready_0, Req_Ready_1, Resp_Valid_0, Resp_Valid_1,
        output Resp_Read_Data_0, Resp_Read_Data_1,
        output Address, Write_Data, Sig_Mem_Write, Sig_Mem_Read, Busy
    );

    modport master (
        output Req_Valid_0, Req_Valid_1, Req_Write_0, Req_Write_1,
        output Req_Address_0, Req_Address_1, Req_Write_Data_0, Req_Write_Data_1,
        output Read_Data,
        input  Req_Ready_0, Req_Ready_1, Resp_Valid_0, Resp_Valid_1,
        input  Resp_Read_Data_0, Resp_Read_Data_1,
        input  Address, Write_Data, Sig_Mem_Write, Sig_Mem_Read, Busy
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin two-port arbiter issuing one DataMemory access per request
module data_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_grant;
    logic                  owner;
    logic                  wr_q;
    logic                  gnt_1;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge Clk) begin
        if (!Reset_N) state <= IDLE;
        else          state <= state_next;
    end

    // on contention the port that did not win last time gets the grant
    always_comb begin
        gnt_1             = bus.Req_Valid_1 && (!bus.Req_Valid_0 || !last_grant);
        accept            = (state == IDLE) && (bus.Req_Valid_0 || bus.Req_Valid_1);
        state_next        = accept ? ACCESS : IDLE;
        bus.Req_Ready_0   = (state == IDLE) && bus.Req_Valid_0 && !gnt_1;
        bus.Req_Ready_1   = (state == IDLE) && gnt_1;
        bus.Busy          = (state == ACCESS);
        bus.Address       = (state == ACCESS) ? addr_q : '0;
        bus.Write_Data    = (state == ACCESS) ? wdata_q : '0;
        bus.Sig_Mem_Write = (state == ACCESS) && wr_q;
        bus.Sig_Mem_Read  = (state == ACCESS) && !wr_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            last_grant           <= 1'b1;
            owner                <= 1'b0;
            wr_q                 <= 1'b0;
            addr_q               <= '0;
            wdata_q              <= '0;
            bus.Resp_Valid_0     <= 1'b0;
            bus.Resp_Valid_1     <= 1'b0;
            bus.Resp_Read_Data_0 <= '0;
            bus.Resp_Read_Data_1 <= '0;
        end else begin
            bus.Resp_Valid_0 <= (state == ACCESS) && !owner;
            bus.Resp_Valid_1 <= (state == ACCESS) && owner;
            if (state == ACCESS && !owner) bus.Resp_Read_Data_0 <= wr_q ? '0 : bus.Read_Data;
            if (state == ACCESS && owner)  bus.Resp_Read_Data_1 <= wr_q ? '0 : bus.Read_Data;
            if (accept) begin
                owner      <= gnt_1;
                last_grant <= gnt_1;
                wr_q       <= gnt_1 ? bus.Req_Write_1 : bus.Req_Write_0;
                addr_q     <= gnt_1 ? bus.Req_Address_1 : bus.Req_Address_0;
                wdata_q    <= gnt_1 ? bus.Req_Write_Data_1 : bus.Req_Write_Data_0;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed tests of arbitration, sequencing and reset behaviour
module tb_data_memory_arbiter;
    logic Clk = 1'b0;
    logic Reset_N = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] mem [0:15] = '{default: 32'h0};

    data_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .Clk(Clk),
        .Reset_N(Reset_N),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // small DataMemory model: combinational read, write on rising edge
    assign bus.Read_Data = mem[bus.Address[3:0]];
    always @(posedge Clk) if (bus.Sig_Mem_Write) mem[bus.Address[3:0]] <= bus.Write_Data;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input bit p, input bit v, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            bus.Req_Valid_1 = v; bus.Req_Write_1 = wr; bus.Req_Address_1 = a; bus.Req_Write_Data_1 = d;
        end else begin
            bus.Req_Valid_0 = v; bus.Req_Write_0 = wr; bus.Req_Address_0 = a; bus.Req_Write_Data_0 = d;
        end
    endtask

    task automatic issue(input bit p, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        set_req(p, 1'b1, wr, a, d);
        #1;
        while (!(p ? bus.Req_Ready_1 : bus.Req_Ready_0) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 10) begin failures++; $display("FAIL issue_timeout port=%0d got=no_ready exp=ready", p); end
        tick();
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'd9, 32'h99);
        tick();
        tick();
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.Busy); end
        checks++; if (bus.Sig_Mem_Write !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%0b exp=0", bus.Sig_Mem_Write); end
        checks++; if (bus.Sig_Mem_Read !== 1'b0) begin failures++; $display("FAIL rst_mem_read got=%0b exp=0", bus.Sig_Mem_Read); end
        checks++; if ({bus.Resp_Valid_0, bus.Resp_Valid_1} !== 2'b00) begin failures++; $display("FAIL rst_resp_valid got=%b exp=00", {bus.Resp_Valid_0, bus.Resp_Valid_1}); end
        checks++; if (bus.Resp_Read_Data_0 !== 32'h0) begin failures++; $display("FAIL rst_resp_data0 got=%h exp=0", bus.Resp_Read_Data_0); end
        checks++; if (bus.Resp_Read_Data_1 !== 32'h0) begin failures++; $display("FAIL rst_resp_data1 got=%h exp=0", bus.Resp_Read_Data_1); end
        checks++; if (bus.Address !== 32'h0 || bus.Write_Data !== 32'h0) begin failures++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", bus.Address, bus.Write_Data); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        Reset_N = 1'b1;
        tick();
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rst_no_handshake got=%0b exp=0", bus.Busy); end
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 1'b1, 32'd3, 32'd150);
        #1;
        checks++; if ({bus.Req_Ready_0, bus.Req_Ready_1} !== 2'b10) begin failures++; $display("FAIL wr_ready got=%b exp=10", {bus.Req_Ready_0, bus.Req_Ready_1}); end
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if ({bus.Sig_Mem_Write, bus.Sig_Mem_Read, bus.Busy} !== 3'b101) begin failures++; $display("FAIL wr_access got=%b exp=101", {bus.Sig_Mem_Write, bus.Sig_Mem_Read, bus.Busy}); end
        checks++; if (bus.Address !== 32'd3 || bus.Write_Data !== 32'd150) begin failures++; $display("FAIL wr_bus got=%0d/%0d exp=3/150", bus.Address, bus.Write_Data); end
        checks++; if (bus.Req_Ready_0 !== 1'b0) begin failures++; $display("FAIL wr_ready_access got=%0b exp=0", bus.Req_Ready_0); end
        tick();
        checks++; if ({bus.Resp_Valid_0, bus.Resp_Valid_1} !== 2'b10) begin failures++; $display("FAIL wr_resp got=%b exp=10", {bus.Resp_Valid_0, bus.Resp_Valid_1}); end
        checks++; if (bus.Sig_Mem_Write !== 1'b0 || bus.Address !== 32'h0) begin failures++; $display("FAIL wr_after got=%0b/%h exp=0/0", bus.Sig_Mem_Write, bus.Address); end
        tick();
        checks++; if (bus.Resp_Valid_0 !== 1'b0) begin failures++; $display("FAIL wr_resp_pulse got=%0b exp=0", bus.Resp_Valid_0); end
        set_req(0, 1'b1, 1'b0, 32'd3, 32'h0);
        #1;
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if ({bus.Sig_Mem_Read, bus.Sig_Mem_Write} !== 2'b10) begin failures++; $display("FAIL rd_access got=%b exp=10", {bus.Sig_Mem_Read, bus.Sig_Mem_Write}); end
        tick();
        checks++; if (bus.Resp_Valid_0 !== 1'b1 || bus.Resp_Read_Data_0 !== 32'd150) begin failures++; $display("FAIL rd_data got=%0b/%0d exp=1/150", bus.Resp_Valid_0, bus.Resp_Read_Data_0); end
        tick();
    endtask

    task automatic test_cross_port();
        set_req(1, 1'b1, 1'b1, 32'd7, 32'hDEADBEEF);
        #1;
        checks++; if ({bus.Req_Ready_0, bus.Req_Ready_1} !== 2'b01) begin failures++; $display("FAIL xp_ready got=%b exp=01", {bus.Req_Ready_0, bus.Req_Ready_1}); end
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.Address !== 32'd7 || bus.Write_Data !== 32'hDEADBEEF) begin failures++; $display("FAIL xp_wr_bus got=%h/%h exp=7/deadbeef", bus.Address, bus.Write_Data); end
        tick();
        checks++; if ({bus.Resp_Valid_0, bus.Resp_Valid_1} !== 2'b01 || bus.Resp_Read_Data_1 !== 32'h0) begin failures++; $display("FAIL xp_wr_resp got=%b/%h exp=01/0", {bus.Resp_Valid_0, bus.Resp_Valid_1}, bus.Resp_Read_Data_1); end
        tick();
        set_req(0, 1'b1, 1'b0, 32'd7, 32'h0);
        #1;
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checks++; if ({bus.Resp_Valid_0, bus.Resp_Valid_1} !== 2'b10) begin failures++; $display("FAIL xp_rd_owner got=%b exp=10", {bus.Resp_Valid_0, bus.Resp_Valid_1}); end
        checks++; if (bus.Resp_Read_Data_0 !== 32'hDEADBEEF) begin failures++; $display("FAIL xp_rd_data got=%h exp=deadbeef", bus.Resp_Read_Data_0); end
        tick();
    endtask

    task automatic test_contention();
        int accepts = 0;
        issue(0, 1'b1, 32'd0, 32'h11);
        issue(0, 1'b1, 32'd1, 32'h22);
        Reset_N = 1'b0;
        tick();
        tick();
        Reset_N = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'd1, 32'h0);
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.Req_Ready_0 !== (i % 4 == 0)) begin failures++; $display("FAIL ct_ready0 cyc=%0d got=%0b exp=%0b", i, bus.Req_Ready_0, i % 4 == 0); end
            checks++; if (bus.Req_Ready_1 !== (i % 4 == 2)) begin failures++; $display("FAIL ct_ready1 cyc=%0d got=%0b exp=%0b", i, bus.Req_Ready_1, i % 4 == 2); end
            checks++; if (bus.Resp_Valid_0 !== (i % 4 == 2)) begin failures++; $display("FAIL ct_resp0 cyc=%0d got=%0b exp=%0b", i, bus.Resp_Valid_0, i % 4 == 2); end
            checks++; if (bus.Resp_Valid_1 !== (i % 4 == 0 && i > 0)) begin failures++; $display("FAIL ct_resp1 cyc=%0d got=%0b exp=%0b", i, bus.Resp_Valid_1, i % 4 == 0 && i > 0); end
            if (i == 2) begin
                checks++; if (bus.Resp_Read_Data_0 !== 32'h11) begin failures++; $display("FAIL ct_data0 got=%h exp=11", bus.Resp_Read_Data_0); end
            end
            if (i == 4) begin
                checks++; if (bus.Resp_Read_Data_1 !== 32'h22) begin failures++; $display("FAIL ct_data1 got=%h exp=22", bus.Resp_Read_Data_1); end
            end
            accepts += int'(bus.Req_Ready_0) + int'(bus.Req_Ready_1);
            tick();
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (accepts != 4) begin failures++; $display("FAIL ct_accepts got=%0d exp=4", accepts); end
        checks++; if (bus.Resp_Valid_1 !== 1'b1 || bus.Resp_Read_Data_1 !== 32'h22) begin failures++; $display("FAIL ct_last_resp got=%0b/%h exp=1/22", bus.Resp_Valid_1, bus.Resp_Read_Data_1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int reads = 0;
        set_req(0, 1'b1, 1'b0, 32'd3, 32'h0);
        #1;
        checks++; if (bus.Req_Ready_0 !== 1'b1) begin failures++; $display("FAIL bb_ready0 got=%0b exp=1", bus.Req_Ready_0); end
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'd7, 32'h0);
        #1;
        checks++; if (bus.Req_Ready_1 !== 1'b0 || bus.Busy !== 1'b1) begin failures++; $display("FAIL bb_hold got=%0b/%0b exp=0/1", bus.Req_Ready_1, bus.Busy); end
        tick();
        checks++; if (bus.Resp_Valid_0 !== 1'b1 || bus.Resp_Read_Data_0 !== 32'd150) begin failures++; $display("FAIL bb_resp0 got=%0b/%0d exp=1/150", bus.Resp_Valid_0, bus.Resp_Read_Data_0); end
        checks++; if (bus.Req_Ready_1 !== 1'b1) begin failures++; $display("FAIL bb_ready1 got=%0b exp=1", bus.Req_Ready_1); end
        tick();
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.Address !== 32'd7) begin failures++; $display("FAIL bb_addr got=%0d exp=7", bus.Address); end
        for (int i = 0; i < 4; i++) begin
            reads += int'(bus.Sig_Mem_Read);
            if (i == 1) begin
                checks++; if (bus.Resp_Valid_1 !== 1'b1 || bus.Resp_Read_Data_1 !== 32'hDEADBEEF) begin failures++; $display("FAIL bb_resp1 got=%0b/%h exp=1/deadbeef", bus.Resp_Valid_1, bus.Resp_Read_Data_1); end
            end
            tick();
        end
        checks++; if (reads != 1) begin failures++; $display("FAIL bb_issue_once got=%0d exp=1", reads); end
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 1'b1, 32'd5, 32'h55);
        #1;
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        Reset_N = 1'b0;
        checks++; if (bus.Sig_Mem_Write !== 1'b1 || bus.Address !== 32'd5) begin failures++; $display("FAIL rm_access got=%0b/%0d exp=1/5", bus.Sig_Mem_Write, bus.Address); end
        tick();
        Reset_N = 1'b1;
        checks++; if ({bus.Sig_Mem_Write, bus.Sig_Mem_Read, bus.Busy} !== 3'b000) begin failures++; $display("FAIL rm_quiet got=%b exp=000", {bus.Sig_Mem_Write, bus.Sig_Mem_Read, bus.Busy}); end
        checks++; if (bus.Resp_Valid_0 !== 1'b0) begin failures++; $display("FAIL rm_no_resp_a got=%0b exp=0", bus.Resp_Valid_0); end
        tick();
        checks++; if (bus.Resp_Valid_0 !== 1'b0) begin failures++; $display("FAIL rm_no_resp_b got=%0b exp=0", bus.Resp_Valid_0); end
        set_req(0, 1'b1, 1'b0, 32'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'd1, 32'h0);
        #1;
        checks++; if ({bus.Req_Ready_0, bus.Req_Ready_1} !== 2'b10) begin failures++; $display("FAIL rm_grant got=%b exp=10", {bus.Req_Ready_0, bus.Req_Ready_1}); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_idle_quiet();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({bus.Sig_Mem_Read, bus.Sig_Mem_Write, bus.Busy} !== 3'b000) begin failures++; $display("FAIL iq_mem cyc=%0d got=%b exp=000", i, {bus.Sig_Mem_Read, bus.Sig_Mem_Write, bus.Busy}); end
            checks++; if ({bus.Resp_Valid_0, bus.Resp_Valid_1} !== 2'b00) begin failures++; $display("FAIL iq_resp cyc=%0d got=%b exp=00", i, {bus.Resp_Valid_0, bus.Resp_Valid_1}); end
        end
    endtask

    initial begin
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_write_read();
        test_cross_port();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_idle_quiet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
